// File: rtl/request_arbiter_if.sv
// request_arbiter_if
// Bundles the requester-side and downstream-side handshakes of the request
// arbiter.
//   req_valid_in  [SIGNALS]               requester i has a request
//   req_data_in   [SIGNALS][DATA_WIDTH]   requester payloads
//   req_ready_out [SIGNALS]               one-hot-or-zero grant, same cycle
//   out_valid_out                         output slot holds a request
//   out_ready_in                          downstream accepts the slot
//   out_data_out  [DATA_WIDTH]            registered winning payload
//   out_id_out    [$clog2(SIGNALS)]       owner index of out_data_out
//   out_boosted_out                       slot was won through starvation boost
// Modports: slave is the arbiter itself; master is the surrounding system,
// which drives the requests and the downstream ready.
interface request_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int SIGNALS    = 2
);
  logic [SIGNALS-1:0]                 req_valid_in;
  logic [SIGNALS-1:0][DATA_WIDTH-1:0] req_data_in;
  logic [SIGNALS-1:0]                 req_ready_out;
  logic                               out_valid_out;
  logic                               out_ready_in;
  logic [DATA_WIDTH-1:0]              out_data_out;
  logic [$clog2(SIGNALS)-1:0]         out_id_out;
  logic                               out_boosted_out;

  modport slave (
    input  req_valid_in, req_data_in, out_ready_in,
    output req_ready_out, out_valid_out, out_data_out, out_id_out, out_boosted_out
  );

  modport master (
    output req_valid_in, req_data_in, out_ready_in,
    input  req_ready_out, out_valid_out, out_data_out, out_id_out, out_boosted_out
  );
endinterface

// File: rtl/request_arbiter.sv
// request_arbiter
// Shares one downstream port between SIGNALS requesters. Index 0 has the
// highest fixed priority. A per-requester saturating wait counter lifts a
// requester that has waited STARVE_LIMIT cycles above the fixed order.
// STARVE_LIMIT = 0 gives pure fixed priority. The winner lands in one
// registered output slot, which is refilled whenever it is empty or is
// being consumed.
//   clk_in    rising-edge clock
//   rst_N_in  synchronous active-low reset
//   bus       request_arbiter_if.slave (requester and downstream handshakes)
module request_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int SIGNALS      = 2,
  parameter int STARVE_LIMIT = 8
) (
  input logic              clk_in,
  input logic              rst_N_in,
  request_arbiter_if.slave bus
);

  localparam int ID_W  = $clog2(SIGNALS);
  localparam int CNT_W = (STARVE_LIMIT > 32'sd0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
  localparam logic             BOOST_EN = (STARVE_LIMIT > 32'sd0);

  logic [CNT_W-1:0]      cnt_r [SIGNALS];
  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [ID_W-1:0]       out_id_r;
  logic                  out_boosted_r;

  logic                  load_s;
  logic [SIGNALS-1:0]    starved_s;
  logic                  win_found_s;
  logic [ID_W-1:0]       win_id_s;
  logic                  boosted_s;
  logic [SIGNALS-1:0]    grant_s;

  // Lowest set bit index of a request vector (0 when empty).
  function automatic logic [ID_W-1:0] lowest_idx(input logic [SIGNALS-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = SIGNALS - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = ID_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Starved set, winner selection and the same-cycle grant.
  always_comb begin
    load_s      = !out_valid_r || bus.out_ready_in;
    starved_s   = '0;
    win_found_s = 1'b0;
    win_id_s    = '0;
    boosted_s   = 1'b0;
    grant_s     = '0;
    for (int i = 0; i < SIGNALS; i++) begin
      starved_s[i] = BOOST_EN && bus.req_valid_in[i] && (cnt_r[i] == LIMIT);
    end
    if (|starved_s) begin
      win_found_s = 1'b1;
      win_id_s    = lowest_idx(starved_s);
      boosted_s   = 1'b1;
    end else if (|bus.req_valid_in) begin
      win_found_s = 1'b1;
      win_id_s    = lowest_idx(bus.req_valid_in);
      boosted_s   = 1'b0;
    end else begin
      win_found_s = 1'b0;
      win_id_s    = '0;
      boosted_s   = 1'b0;
    end
    // No grant while in reset: the requester would otherwise believe it was
    // accepted while the slot is being cleared.
    if (rst_N_in && load_s && win_found_s) begin
      grant_s[win_id_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  // Output slot: refill on load, hold while stalled.
  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      out_valid_r   <= 1'b0;
      out_data_r    <= '0;
      out_id_r      <= '0;
      out_boosted_r <= 1'b0;
    end else if (load_s && win_found_s) begin
      out_valid_r   <= 1'b1;
      out_data_r    <= bus.req_data_in[win_id_s];
      out_id_r      <= win_id_s;
      out_boosted_r <= boosted_s;
    end else if (load_s) begin
      out_valid_r   <= 1'b0;
    end else begin
      out_valid_r   <= out_valid_r;
    end
  end

  // Wait counters: clear when idle or granted, otherwise count up to the
  // limit. They keep counting through downstream stalls.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < SIGNALS; i++) begin
      if (!rst_N_in) begin
        cnt_r[i] <= '0;
      end else if (!bus.req_valid_in[i] || grant_s[i]) begin
        cnt_r[i] <= '0;
      end else if (cnt_r[i] != LIMIT) begin
        cnt_r[i] <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r[i] <= cnt_r[i];
      end
    end
  end

  assign bus.req_ready_out   = grant_s;
  assign bus.out_valid_out   = out_valid_r;
  assign bus.out_data_out    = out_data_r;
  assign bus.out_id_out      = out_id_r;
  assign bus.out_boosted_out = out_boosted_r;

endmodule

// File: tb/tb_request_arbiter.sv
// tb_request_arbiter
// Table-driven bench for request_arbiter (SIGNALS=4, DATA_WIDTH=8).
// Instance a uses STARVE_LIMIT=3; instance b uses STARVE_LIMIT=0.
// Each table row is driven at the falling edge. Checks run 1 time unit later:
// the combinational grant is checked against this row's inputs, and the
// registered slot is checked as left by the previous rising edge.
module tb_request_arbiter;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  request_arbiter_if #(.DATA_WIDTH(8), .SIGNALS(4)) ifa ();
  request_arbiter_if #(.DATA_WIDTH(8), .SIGNALS(4)) ifb ();

  request_arbiter #(.DATA_WIDTH(8), .SIGNALS(4), .STARVE_LIMIT(3)) dut_a (
    .clk_in(clk), .rst_N_in(rst_a), .bus(ifa.slave)
  );
  request_arbiter #(.DATA_WIDTH(8), .SIGNALS(4), .STARVE_LIMIT(0)) dut_b (
    .clk_in(clk), .rst_N_in(rst_b), .bus(ifb.slave)
  );

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic [31:0] data;   // {req3, req2, req1, req0}
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [1:0]  e_id;
    logic        e_bo;
    logic        chk_d;  // compare data/id/boosted too
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [31:0] d,
                              input logic o, input logic [3:0] er, input logic eov,
                              input logic [7:0] eod, input logic [1:0] eid,
                              input logic ebo, input logic cd);
    vec_t t;
    t.rst_n = r; t.valid = v; t.data = d; t.ordy = o;
    t.e_rdy = er; t.e_ov = eov; t.e_od = eod; t.e_id = eid; t.e_bo = ebo; t.chk_d = cd;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  localparam logic [31:0] D0 = 32'h33C211A0;
  localparam logic [31:0] DA = 32'h33C211AA;

  initial begin
    // Reset hold, priority, backpressure, boost, idle drain, mid-op reset.
    vq.push_back(mk(1'b0, 4'b1111, D0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1)); // 0
    vq.push_back(mk(1'b0, 4'b1111, D0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1)); // 1
    vq.push_back(mk(1'b1, 4'b1111, D0, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1)); // 2
    vq.push_back(mk(1'b1, 4'b1010, D0, 1'b1, 4'b0010, 1'b1, 8'hA0, 2'd0, 1'b0, 1'b1)); // 3
    vq.push_back(mk(1'b1, 4'b1000, D0, 1'b1, 4'b1000, 1'b1, 8'h11, 2'd1, 1'b0, 1'b1)); // 4
    vq.push_back(mk(1'b1, 4'b0000, D0, 1'b1, 4'b0000, 1'b1, 8'h33, 2'd3, 1'b0, 1'b1)); // 5
    vq.push_back(mk(1'b1, 4'b0001, DA, 1'b0, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0)); // 6
    for (int k = 0; k < 5; k++) begin                                                 // 7..11
      vq.push_back(mk(1'b1, 4'b0101, DA, 1'b0, 4'b0000, 1'b1, 8'hAA, 2'd0, 1'b0, 1'b1));
    end
    vq.push_back(mk(1'b1, 4'b0101, DA, 1'b1, 4'b0001, 1'b1, 8'hAA, 2'd0, 1'b0, 1'b1)); // 12
    vq.push_back(mk(1'b1, 4'b0100, DA, 1'b1, 4'b0100, 1'b1, 8'hAA, 2'd0, 1'b1, 1'b1)); // 13
    vq.push_back(mk(1'b1, 4'b0000, DA, 1'b1, 4'b0000, 1'b1, 8'hC2, 2'd2, 1'b1, 1'b1)); // 14
    vq.push_back(mk(1'b1, 4'b0101, 32'h33C21140, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0)); // 15
    vq.push_back(mk(1'b1, 4'b0101, 32'h33C21141, 1'b1, 4'b0001, 1'b1, 8'h40, 2'd0, 1'b0, 1'b1)); // 16
    vq.push_back(mk(1'b1, 4'b0101, 32'h33C21142, 1'b1, 4'b0001, 1'b1, 8'h41, 2'd0, 1'b0, 1'b1)); // 17
    vq.push_back(mk(1'b1, 4'b0101, 32'h33C21143, 1'b1, 4'b0100, 1'b1, 8'h42, 2'd0, 1'b0, 1'b1)); // 18
    vq.push_back(mk(1'b1, 4'b0101, 32'h33C21143, 1'b1, 4'b0001, 1'b1, 8'hC2, 2'd2, 1'b1, 1'b1)); // 19
    vq.push_back(mk(1'b1, 4'b0000, 32'h33C21143, 1'b1, 4'b0000, 1'b1, 8'h43, 2'd0, 1'b0, 1'b1)); // 20
    vq.push_back(mk(1'b1, 4'b1000, 32'h5CC211A0, 1'b1, 4'b1000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0)); // 21
    vq.push_back(mk(1'b1, 4'b0000, 32'h5CC211A0, 1'b1, 4'b0000, 1'b1, 8'h5C, 2'd3, 1'b0, 1'b1)); // 22
    vq.push_back(mk(1'b1, 4'b0000, 32'h5CC211A0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0)); // 23
    vq.push_back(mk(1'b1, 4'b0010, 32'h33C277A0, 1'b0, 4'b0010, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0)); // 24
    vq.push_back(mk(1'b1, 4'b0000, 32'h33C277A0, 1'b0, 4'b0000, 1'b1, 8'h77, 2'd1, 1'b0, 1'b1)); // 25
    vq.push_back(mk(1'b0, 4'b0000, 32'h33C277A0, 1'b0, 4'b0000, 1'b1, 8'h77, 2'd1, 1'b0, 1'b1)); // 26
    vq.push_back(mk(1'b1, 4'b0000, 32'h33C277A0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1)); // 27
    vq.push_back(mk(1'b1, 4'b0000, 32'h33C277A0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1)); // 28

    // One reset edge on both instances so the table starts from a known slot.
    rst_a = 1'b0;
    rst_b = 1'b0;
    ifa.req_valid_in = 4'b0000;
    ifa.req_data_in  = '0;
    ifa.out_ready_in = 1'b1;
    ifb.req_valid_in = 4'b0000;
    ifb.req_data_in  = '0;
    ifb.out_ready_in = 1'b1;
    @(negedge clk);

    for (int n = 0; n < vq.size(); n++) begin
      rst_a            = vq[n].rst_n;
      ifa.req_valid_in = vq[n].valid;
      ifa.req_data_in  = vq[n].data;
      ifa.out_ready_in = vq[n].ordy;
      #1;
      chk($sformatf("v%0d req_ready", n), {28'd0, ifa.req_ready_out}, {28'd0, vq[n].e_rdy});
      chk($sformatf("v%0d out_valid", n), {31'd0, ifa.out_valid_out}, {31'd0, vq[n].e_ov});
      if (vq[n].chk_d) begin
        chk($sformatf("v%0d out_data", n), {24'd0, ifa.out_data_out}, {24'd0, vq[n].e_od});
        chk($sformatf("v%0d out_id", n), {30'd0, ifa.out_id_out}, {30'd0, vq[n].e_id});
        chk($sformatf("v%0d out_boosted", n), {31'd0, ifa.out_boosted_out}, {31'd0, vq[n].e_bo});
      end
      @(negedge clk);
    end

    // With boosting disabled, req 2 never wins against a busy req 0.
    rst_b = 1'b1;
    for (int k = 0; k < 20; k++) begin
      logic [7:0] d0;
      d0 = 8'h40 + 8'(k);
      ifb.req_valid_in = 4'b0101;
      ifb.req_data_in  = {8'h33, 8'hC2, 8'h11, d0};
      ifb.out_ready_in = 1'b1;
      #1;
      chk($sformatf("nb%0d req_ready", k), {28'd0, ifb.req_ready_out}, 32'h1);
      chk($sformatf("nb%0d out_boosted", k), {31'd0, ifb.out_boosted_out}, 32'h0);
      if (k > 0) begin
        chk($sformatf("nb%0d out_valid", k), {31'd0, ifb.out_valid_out}, 32'h1);
        chk($sformatf("nb%0d out_id", k), {30'd0, ifb.out_id_out}, 32'h0);
        chk($sformatf("nb%0d out_data", k), {24'd0, ifb.out_data_out}, {24'd0, d0 - 8'h01});
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/request_arbiter.md
Name: request_arbiter

Overview:
- Shares one downstream memory-subsystem port between SIGNALS requesters, each with a valid/ready handshake.
- Fixed priority: index 0 is highest, matching the team's priority_mux convention. A saturating wait counter per requester boosts any requester starved for STARVE_LIMIT cycles.
- The winner's payload and index go into a single registered output slot. The block sits between request sources (L1 miss queues, prefetcher, writeback) and the next-level cache or memory controller.

Parameters:
- DATA_WIDTH, 64, payload width per requester.
- SIGNALS, 2, number of requesters (≥2).
- STARVE_LIMIT, 8, wait cycles before a requester is boosted. 0 disables boosting (pure fixed priority).

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_N_in  input  1  synchronous reset, active-low.
- req_valid_in  input  [SIGNALS]  requester i has a request.
- req_data_in  input  [DATA_WIDTH-1:0] x SIGNALS  requester payloads.
- req_ready_out  output  [SIGNALS]  one-hot-or-zero; requester i accepted this cycle.
- out_valid_out  output  1  output slot holds a request.
- out_ready_in  input  1  downstream accepts the slot this cycle.
- out_data_out  output  [DATA_WIDTH-1:0]  registered winning payload.
- out_id_out  output  [$clog2(SIGNALS)-1:0]  index of the requester that owns out_data_out.
- out_boosted_out  output  1  slot was won through starvation boost (debug/perf).

Behaviour:
- **Reset** (rst_N_in=0 at an edge):
  - out_valid_out=0, out_data_out=0, out_id_out=0, out_boosted_out=0.
  - All wait counters cleared to 0.
  - req_ready_out is 0 during reset cycles, regardless of inputs.
  - A reset mid-operation drops the slot contents without delivering them.
- **Load condition:** load = !out_valid_out || out_ready_in. This is combinational, so full throughput is one request per cycle.
- **Winner selection** (combinational, only when load=1 and at least one req_valid_in is high):
  - Starved set = {i : req_valid_in[i] && cnt[i]==STARVE_LIMIT && STARVE_LIMIT!=0}.
  - If the starved set is non-empty, winner = its lowest index and boosted=1.
  - Otherwise winner = lowest index with req_valid_in high and boosted=0.
- **Grant:** req_ready_out[winner]=1 in the same cycle; all other bits are 0. If load=0 or no request is valid, req_ready_out is all-zero.
- **Edge update when load=1:**
  - With a winner: out_valid_out←1, out_data_out←req_data_in[winner], out_id_out←winner, out_boosted_out←boosted.
  - With no winner: out_valid_out←0. Data, id and boosted hold their old values (don't-care).
- **Edge update when load=0:** slot holds its contents unchanged while valid && !ready.
- **Latency:** a request granted in cycle N appears on out_valid_out in cycle N+1.
- **Wait counters** (width $clog2(STARVE_LIMIT+1), minimum 1 bit), per requester i, at each edge:
  - Cleared if req_valid_in[i]=0 or req_ready_out[i]=1.
  - Otherwise incremented, saturating at STARVE_LIMIT.
  - Counters also increment during load=0 stall cycles. Boost applies at the next load opportunity.
- **Requester protocol:**
  - Requesters hold valid and data stable until ready.
  - Dropping valid early is legal; the counter clears and no grant occurs.
  - Payload is sampled only in the grant cycle.
- **Simultaneous events:**
  - Downstream consume plus a new grant in the same cycle: the slot is replaced seamlessly with no bubble.
  - Several requesters starved at once: lowest index wins. The others keep their saturated counters and win on later loads in index order.
- **Output behaviour:**
  - out_* depend only on registers; there are no combinational paths from req_* to out_*.
  - req_ready_out depends combinationally on req_valid_in, out_valid_out, out_ready_in and the counters.

Test Plan (SIGNALS=4, DATA_WIDTH=8, STARVE_LIMIT=3 unless stated):
1. **Reset hold:** rst_N_in=0 for 2 cycles with all req_valid_in=1 → req_ready_out=0000, out_valid_out=0, out_data_out=0x00. First cycle after release: req_ready_out=0001.
2. **Fixed priority and latency:** req 1 (0x11) and req 3 (0x33) valid, out_ready_in=1 → cycle 0 req_ready_out=0010. Cycle 1: out_valid=1, out_data=0x11, out_id=1. Req 1 then drops, so cycle 1 grants req 3 and cycle 2 shows 0x33, out_id=3.
3. **Backpressure:** out_ready_in=0 with slot full (0xAA, id 0), reqs 0 and 2 valid for 5 cycles → req_ready_out=0000 and slot stable at 0xAA. On release, req 0 is granted.
4. **Starvation boost:** req 0 valid with new data every cycle, req 2 valid continuously, out_ready_in=1 → req 0 granted cycles 0–2 while cnt[2] reaches 3. Cycle 3 grants req 2. Cycle 4 shows out_id=2, out_boosted_out=1, and cnt[2] is 0.
5. **Boost disabled (STARVE_LIMIT=0):** same stimulus as scenario 4 for 20 cycles → req 2 is never granted and out_boosted_out stays 0.
6. **Idle drain and mid-op reset:**
   - Single request 0x5C on req 3 is consumed, then all req_valid_in go low → out_valid_out falls to 0 the cycle after consumption.
   - Separately, assert reset while the slot is full and stalled → out_valid_out=0 next cycle and the request is not delivered.
